// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage.
//   BR_*    : branch operation codes presented on i_BranchOpD
//   PCSEL_* : next-PC source selects presented on i_PC_SelD
//   FWD_*   : compare-operand forward selects (i_ForwardAD / i_ForwardBD)
//   br_uses_rt() : true for branches that compare rs against rt
package decode_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BLEZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;
  localparam logic [2:0] BR_RSVD = 3'd7;

  localparam logic [1:0] PCSEL_BRANCH = 2'd0;
  localparam logic [1:0] PCSEL_REG    = 2'd1;
  localparam logic [1:0] PCSEL_JUMP   = 2'd2;
  localparam logic [1:0] PCSEL_NONE   = 2'd3;

  localparam logic [1:0] FWD_RF     = 2'd0;
  localparam logic [1:0] FWD_MEM    = 2'd1;
  localparam logic [1:0] FWD_WB     = 2'd2;
  localparam logic [1:0] FWD_RF_ALT = 2'd3;

  function automatic logic br_uses_rt(input logic [2:0] op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

endpackage

// File: rtl/decode_stage_pipelined_regfile_bypass.sv
// Register file with two combinational read ports, one synchronous write
// port and write-back bypass.
//   clk, rst_n         : clock, synchronous active-low clear of every register
//   we, waddr, wdata   : write port (writes to register 0 are ignored)
//   raddr_a/b, rdata_a/b : read ports; register 0 reads 0, a read of the
//                        register being written this cycle returns wdata
module regfile_bypass #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [RF_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [RF_ADDR_WIDTH-1:0] raddr_a,
  input  logic [RF_ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0]    rdata_a,
  output logic [DATA_WIDTH-1:0]    rdata_b
);

  localparam int DEPTH = 2 ** RF_ADDR_WIDTH;

  // Whole-array clear on reset rules out block RAM; this is a flop array.
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle WB data wins over the stored value so ID never sees stale data.
  assign rdata_a = (raddr_a == '0)               ? '0    :
                   (we && (raddr_a == waddr))    ? wdata : regs[raddr_a];
  assign rdata_b = (raddr_b == '0)               ? '0    :
                   (we && (raddr_b == waddr))    ? wdata : regs[raddr_b];

endmodule

// File: rtl/decode_stage_pipelined.sv
// Instruction decode stage with its own ID/EX pipeline register.
// Reads the register file (with WB bypass), extends the immediate, resolves
// branches/jumps with forwarded compare operands, detects load-use and
// branch-operand hazards, and registers the decoded instruction into EX.
// Ports (see names): i_CLK/i_RST (sync active-low), ID inputs *D, forwarding
// sources from MEM (*M) and WB (*W), i_FlushE; outputs o_StallD, the fetch
// redirect o_PCSrcD/o_PCNextD, and the registered EX fields o_*E.
module decode_stage_pipelined
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_ValidD,
  input  logic [31:0]              i_InstrD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4D,
  input  logic [2:0]               i_BranchOpD,
  input  logic [1:0]               i_PC_SelD,
  input  logic                     i_sign_selD,
  input  logic                     i_RegWriteD,
  input  logic                     i_MemReadD,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegD,
  input  logic [1:0]               i_ForwardAD,
  input  logic [1:0]               i_ForwardBD,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic                     i_MemReadM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic                     i_RegWriteW,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic [DATA_WIDTH-1:0]    i_ResultW,
  input  logic                     i_FlushE,
  output logic                     o_StallD,
  output logic                     o_PCSrcD,
  output logic [ADDRESS_WIDTH-1:0] o_PCNextD,
  output logic                     o_ValidE,
  output logic [DATA_WIDTH-1:0]    o_SrcAE,
  output logic [DATA_WIDTH-1:0]    o_SrcBE,
  output logic [DATA_WIDTH-1:0]    o_SignImmE,
  output logic [4:0]               o_ShamtE,
  output logic [RF_ADDR_WIDTH-1:0] o_RsE,
  output logic [RF_ADDR_WIDTH-1:0] o_RtE,
  output logic [RF_ADDR_WIDTH-1:0] o_RdE,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegE,
  output logic                     o_RegWriteE,
  output logic                     o_MemReadE
);

  localparam int AW  = ADDRESS_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int RAW = RF_ADDR_WIDTH;

  // Opcode bits are decoded upstream; kept here only to keep the port whole.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^i_InstrD[31:26];

  logic [RAW-1:0] rs, rt, rd;
  assign rs = RAW'(i_InstrD[25:21]);
  assign rt = RAW'(i_InstrD[20:16]);
  assign rd = RAW'(i_InstrD[15:11]);

  logic [DW-1:0] rf_a, rf_b;

  regfile_bypass #(
    .DATA_WIDTH   (DW),
    .RF_ADDR_WIDTH(RAW)
  ) u_regfile (
    .clk    (i_CLK),
    .rst_n  (i_RST),
    .we     (i_RegWriteW),
    .waddr  (i_WriteRegW),
    .wdata  (i_ResultW),
    .raddr_a(rs),
    .raddr_b(rt),
    .rdata_a(rf_a),
    .rdata_b(rf_b)
  );

  // Immediate and branch target (target offset always sign-extended).
  logic [15:0]   imm16;
  logic [DW-1:0] sign_imm;
  logic [AW-1:0] branch_target;
  assign imm16         = i_InstrD[15:0];
  assign sign_imm      = i_sign_selD ? {{(DW-16){1'b0}}, imm16}
                                     : {{(DW-16){imm16[15]}}, imm16};
  assign branch_target = i_PCPlus4D + {{(AW-18){imm16[15]}}, imm16, 2'b00};

  // Compare operands after the forward mux.
  logic [DW-1:0] cmp_a, cmp_b;
  always_comb begin
    case (i_ForwardAD)
      FWD_MEM: cmp_a = i_ALUOutM;
      FWD_WB:  cmp_a = i_ResultW;
      default: cmp_a = rf_a;
    endcase
    case (i_ForwardBD)
      FWD_MEM: cmp_b = i_ALUOutM;
      FWD_WB:  cmp_b = i_ResultW;
      default: cmp_b = rf_b;
    endcase
  end

  // Zero tests on A are signed: the sign bit alone decides negative.
  logic a_neg, a_zero, taken;
  assign a_neg  = cmp_a[DW-1];
  assign a_zero = (cmp_a == '0);
  always_comb begin
    case (i_BranchOpD)
      BR_BEQ:  taken = (cmp_a == cmp_b);
      BR_BNE:  taken = (cmp_a != cmp_b);
      BR_BGTZ: taken = !a_neg && !a_zero;
      BR_BLTZ: taken = a_neg;
      BR_BLEZ: taken = a_neg || a_zero;
      BR_BGEZ: taken = !a_neg;
      default: taken = 1'b0;
    endcase
  end

  // Register-indirect target, resized from the data width to the PC width.
  logic [AW-1:0] reg_target, jump_target;
  if (AW <= DW) begin : g_reg_narrow
    assign reg_target = cmp_a[AW-1:0];
  end else begin : g_reg_wide
    assign reg_target = {{(AW-DW){1'b0}}, cmp_a};
  end
  if (AW > 28) begin : g_jump_region
    assign jump_target = {i_PCPlus4D[AW-1:28], i_InstrD[25:0], 2'b00};
  end else begin : g_jump_flat
    assign jump_target = {i_InstrD[25:0], 2'b00};
  end

  always_comb begin
    case (i_PC_SelD)
      PCSEL_BRANCH: o_PCNextD = branch_target;
      PCSEL_REG:    o_PCNextD = reg_target;
      PCSEL_JUMP:   o_PCNextD = jump_target;
      default:      o_PCNextD = i_PCPlus4D;
    endcase
  end

  // Hazards. Branches/JR need their compared sources ready in ID, so an EX
  // writer or a MEM load of such a source stalls; ordinary loads only stall
  // a direct consumer in the next instruction.
  logic uses_rt, branch_check, load_use, e_writer_hit, m_load_hit;
  assign uses_rt      = br_uses_rt(i_BranchOpD);
  assign branch_check = ((i_BranchOpD != BR_NONE) && (i_BranchOpD != BR_RSVD)) ||
                        (i_PC_SelD == PCSEL_REG);
  assign load_use     = o_ValidE && o_MemReadE && (o_WriteRegE != '0) &&
                        ((o_WriteRegE == rs) || (o_WriteRegE == rt));
  assign e_writer_hit = o_ValidE && o_RegWriteE && (o_WriteRegE != '0) &&
                        ((o_WriteRegE == rs) || (uses_rt && (o_WriteRegE == rt)));
  assign m_load_hit   = i_MemReadM && (i_WriteRegM != '0) &&
                        ((i_WriteRegM == rs) || (uses_rt && (i_WriteRegM == rt)));
  assign o_StallD     = i_ValidD && (load_use || (branch_check && (e_writer_hit || m_load_hit)));

  assign o_PCSrcD = i_ValidD && !o_StallD &&
                    ((i_PC_SelD == PCSEL_REG) || (i_PC_SelD == PCSEL_JUMP) ||
                     ((i_PC_SelD == PCSEL_BRANCH) && taken));

  // ID/EX register: a bubble clears only the valid/control bits.
  logic bubble;
  assign bubble = i_FlushE || o_StallD || !i_ValidD;

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      o_ValidE    <= 1'b0;
      o_RegWriteE <= 1'b0;
      o_MemReadE  <= 1'b0;
      o_SrcAE     <= '0;
      o_SrcBE     <= '0;
      o_SignImmE  <= '0;
      o_ShamtE    <= '0;
      o_RsE       <= '0;
      o_RtE       <= '0;
      o_RdE       <= '0;
      o_WriteRegE <= '0;
    end else if (bubble) begin
      o_ValidE    <= 1'b0;
      o_RegWriteE <= 1'b0;
      o_MemReadE  <= 1'b0;
    end else begin
      o_ValidE    <= 1'b1;
      o_RegWriteE <= i_RegWriteD;
      o_MemReadE  <= i_MemReadD;
      o_SrcAE     <= rf_a;
      o_SrcBE     <= rf_b;
      o_SignImmE  <= sign_imm;
      o_ShamtE    <= i_InstrD[10:6];
      o_RsE       <= rs;
      o_RtE       <= rt;
      o_RdE       <= rd;
      o_WriteRegE <= i_WriteRegD;
    end
  end

endmodule
